// File: rtl/wb_retire_buf.sv
// wb_retire_buf: writeback/retire stage after MEM.
// A small in-order FIFO decouples MEM from a stalling register-file/trace
// consumer. Load data is extracted and extended before it is stored, so the
// head entry already holds the final writeback value. Exceptions and ERTN
// retire as one-cycle submit pulses that empty the buffer.
module wb_retire_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic [6:0]        mem_op,
  input  logic              res_from_mem,
  input  logic              gr_we,
  input  logic [4:0]        dest,
  input  logic              has_exception,
  input  logic              ertn,
  input  logic [5:0]        ecode,
  input  logic [8:0]        esubcode,
  input  logic [DATA_W-1:0] exception_maddr,
  input  logic              retire_stall,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic              exception_submit,
  output logic              ertn_submit,
  output logic              this_flush,
  output logic [5:0]        ecode_submit,
  output logic [8:0]        esubcode_submit,
  output logic [31:0]       exception_pc_submit,
  output logic [DATA_W-1:0] exception_maddr_submit
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry storage, one slot per FIFO position.
  logic [31:0]       r_pc     [DEPTH];
  logic [DATA_W-1:0] r_result [DEPTH];
  logic              r_gr_we  [DEPTH];
  logic [4:0]        r_dest   [DEPTH];
  logic              r_exc    [DEPTH];
  logic              r_ertn   [DEPTH];
  logic [5:0]        r_ecode  [DEPTH];
  logic [8:0]        r_esub   [DEPTH];
  logic [DATA_W-1:0] r_maddr  [DEPTH];

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_in_ready;
  logic              w_enq;
  logic              w_head_valid;
  logic              w_retire;
  logic              w_exc_fire;
  logic              w_ertn_fire;
  logic              w_flush;
  logic [OFF_W-1:0]  w_off;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_mem_result;
  logic [DATA_W-1:0] w_final_result;

  // Handshake and retire decisions; in_ready looks only at the registered
  // count so a stalling consumer never reaches MEM combinationally.
  always_comb begin
    w_in_ready   = rst && (r_count < CNT_W'(DEPTH));
    w_enq        = in_valid && w_in_ready;
    w_head_valid = rst && (r_count != '0);
    w_retire     = w_head_valid && !retire_stall;
    w_exc_fire   = w_retire && r_exc[r_rptr];
    w_ertn_fire  = w_retire && r_ertn[r_rptr] && !r_exc[r_rptr];
    w_flush      = w_exc_fire || w_ertn_fire;
  end

  // Load extraction: shift the addressed byte lane down, then extend by type.
  // Misaligned accesses, 64-bit-only ops on a 32-bit path and no op give 0.
  always_comb begin
    w_off        = result[OFF_W-1:0];
    w_shifted    = data_sram_rdata >> {w_off, 3'b000};
    w_mem_result = '0;
    if (mem_op[0]) begin
      w_mem_result = DATA_W'($signed(w_shifted[7:0]));
    end else if (mem_op[1]) begin
      if (!w_off[0]) w_mem_result = DATA_W'($signed(w_shifted[15:0]));
    end else if (mem_op[2]) begin
      if (w_off[1:0] == 2'b00) w_mem_result = DATA_W'($signed(w_shifted[31:0]));
    end else if (mem_op[3]) begin
      w_mem_result = DATA_W'(w_shifted[7:0]);
    end else if (mem_op[4]) begin
      if (!w_off[0]) w_mem_result = DATA_W'(w_shifted[15:0]);
    end else if (mem_op[5]) begin
      if ((DATA_W == 64) && (w_off[1:0] == 2'b00)) w_mem_result = DATA_W'(w_shifted[31:0]);
    end else if (mem_op[6]) begin
      if ((DATA_W == 64) && (w_off == '0)) w_mem_result = w_shifted;
    end
    w_final_result = res_from_mem ? w_mem_result : result;
  end

  // FIFO state: reset and flush both empty the buffer; otherwise enqueue at
  // the write pointer and retire from the read pointer, one of each per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]     <= '0;
        r_result[i] <= '0;
        r_gr_we[i]  <= 1'b0;
        r_dest[i]   <= '0;
        r_exc[i]    <= 1'b0;
        r_ertn[i]   <= 1'b0;
        r_ecode[i]  <= '0;
        r_esub[i]   <= '0;
        r_maddr[i]  <= '0;
      end
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_pc[r_wptr]     <= pc;
        r_result[r_wptr] <= w_final_result;
        r_gr_we[r_wptr]  <= gr_we;
        r_dest[r_wptr]   <= dest;
        r_exc[r_wptr]    <= has_exception;
        r_ertn[r_wptr]   <= ertn;
        r_ecode[r_wptr]  <= ecode;
        r_esub[r_wptr]   <= esubcode;
        r_maddr[r_wptr]  <= exception_maddr;
        r_wptr           <= r_wptr + 1'b1;
      end
      if (w_retire) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_enq, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry drives every output; an empty buffer (or reset) forces zeros.
  always_comb begin
    in_ready               = w_in_ready;
    rf_we                  = 1'b0;
    rf_waddr               = '0;
    rf_wdata               = '0;
    debug_wb_pc            = '0;
    exception_submit       = 1'b0;
    ertn_submit            = 1'b0;
    this_flush             = 1'b0;
    ecode_submit           = '0;
    esubcode_submit        = '0;
    exception_pc_submit    = '0;
    exception_maddr_submit = '0;
    if (w_head_valid) begin
      rf_we                  = w_retire && r_gr_we[r_rptr] && !r_exc[r_rptr];
      rf_waddr               = r_dest[r_rptr];
      rf_wdata               = r_result[r_rptr];
      debug_wb_pc            = r_pc[r_rptr];
      exception_submit       = w_exc_fire;
      ertn_submit            = w_ertn_fire;
      this_flush             = w_flush;
      ecode_submit           = r_ecode[r_rptr];
      esubcode_submit        = r_esub[r_rptr];
      exception_pc_submit    = r_pc[r_rptr];
      exception_maddr_submit = r_maddr[r_rptr];
    end
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

endmodule

// File: tb/tb_wb_retire_buf.sv
// Testbench for wb_retire_buf: table-driven load extraction on a 32-bit and a
// 64-bit instance, plus hand-written reset, full/stall, flush and ERTN sequences.
module tb_wb_retire_buf;

  localparam logic [6:0] OP_LB  = 7'h01;
  localparam logic [6:0] OP_LH  = 7'h02;
  localparam logic [6:0] OP_LW  = 7'h04;
  localparam logic [6:0] OP_LBU = 7'h08;
  localparam logic [6:0] OP_LHU = 7'h10;
  localparam logic [6:0] OP_LWU = 7'h20;
  localparam logic [6:0] OP_LD  = 7'h40;

  typedef struct {
    logic        wide;
    logic [6:0]  memOp;
    logic        resFromMem;
    logic [63:0] result;
    logic [63:0] rdata;
    logic [63:0] expected;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  // Shared narrow inputs
  logic        inValid, resFromMem, grWe, hasExc, ertnIn, retireStall;
  logic [31:0] pc, result, rdata, maddr;
  logic [6:0]  memOp;
  logic [4:0]  dest;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;

  // Inputs specific to the 64-bit instance
  logic        inValidW, resFromMemW;
  logic [63:0] resultW, rdataW, maddrW;
  logic [6:0]  memOpW;

  // 32-bit instance outputs
  logic        inReady, rfWe, excSubmit, ertnSubmit, thisFlush;
  logic [4:0]  rfWaddr, dbgWnum;
  logic [31:0] rfWdata, dbgPc, dbgWdata, excPcSub, maddrSub;
  logic [3:0]  dbgWe;
  logic [5:0]  ecodeSub;
  logic [8:0]  esubSub;

  // 64-bit instance outputs
  logic        inReadyW, rfWeW, excSubmitW, ertnSubmitW, thisFlushW;
  logic [4:0]  rfWaddrW, dbgWnumW;
  logic [63:0] rfWdataW, dbgWdataW, maddrSubW;
  logic [31:0] dbgPcW, excPcSubW;
  logic [3:0]  dbgWeW;
  logic [5:0]  ecodeSubW;
  logic [8:0]  esubSubW;

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[22];

  // Free-running clock
  always #5 clk = ~clk;

  wb_retire_buf #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .pc(pc), .result(result), .data_sram_rdata(rdata), .mem_op(memOp),
    .res_from_mem(resFromMem), .gr_we(grWe), .dest(dest),
    .has_exception(hasExc), .ertn(ertnIn), .ecode(ecode), .esubcode(esubcode),
    .exception_maddr(maddr), .retire_stall(retireStall),
    .rf_we(rfWe), .rf_waddr(rfWaddr), .rf_wdata(rfWdata),
    .debug_wb_pc(dbgPc), .debug_wb_rf_we(dbgWe), .debug_wb_rf_wnum(dbgWnum),
    .debug_wb_rf_wdata(dbgWdata), .exception_submit(excSubmit),
    .ertn_submit(ertnSubmit), .this_flush(thisFlush), .ecode_submit(ecodeSub),
    .esubcode_submit(esubSub), .exception_pc_submit(excPcSub),
    .exception_maddr_submit(maddrSub)
  );

  wb_retire_buf #(.DATA_W(64), .DEPTH(4)) dutW (
    .clk(clk), .rst(rst), .in_valid(inValidW), .in_ready(inReadyW),
    .pc(pc), .result(resultW), .data_sram_rdata(rdataW), .mem_op(memOpW),
    .res_from_mem(resFromMemW), .gr_we(grWe), .dest(dest),
    .has_exception(hasExc), .ertn(ertnIn), .ecode(ecode), .esubcode(esubcode),
    .exception_maddr(maddrW), .retire_stall(retireStall),
    .rf_we(rfWeW), .rf_waddr(rfWaddrW), .rf_wdata(rfWdataW),
    .debug_wb_pc(dbgPcW), .debug_wb_rf_we(dbgWeW), .debug_wb_rf_wnum(dbgWnumW),
    .debug_wb_rf_wdata(dbgWdataW), .exception_submit(excSubmitW),
    .ertn_submit(ertnSubmitW), .this_flush(thisFlushW), .ecode_submit(ecodeSubW),
    .esubcode_submit(esubSubW), .exception_pc_submit(excPcSubW),
    .exception_maddr_submit(maddrSubW)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    inValid = 1'b0; resFromMem = 1'b0; grWe = 1'b0; hasExc = 1'b0;
    ertnIn = 1'b0; retireStall = 1'b0; pc = '0; result = '0; rdata = '0;
    maddr = '0; memOp = '0; dest = '0; ecode = '0; esubcode = '0;
    inValidW = 1'b0; resFromMemW = 1'b0; resultW = '0; rdataW = '0;
    maddrW = '0; memOpW = '0;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pcV,
                               input logic [31:0] resV, input logic grWeV,
                               input logic [4:0] destV, input logic excV,
                               input logic ertnV, input logic [5:0] ecodeV);
    inValid = valid; pc = pcV; result = resV; grWe = grWeV; dest = destV;
    hasExc = excV; ertnIn = ertnV; ecode = ecodeV;
    resFromMem = 1'b0; memOp = '0;
  endtask

  // Watchdog so the bench always ends even if the sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    vecs[0]  = '{1'b0, OP_LB,  1'b1, 64'h1C000003, 64'h80FF7F01, 64'hFFFFFF80};
    vecs[1]  = '{1'b0, OP_LBU, 1'b1, 64'h1C000003, 64'h80FF7F01, 64'h00000080};
    vecs[2]  = '{1'b0, OP_LH,  1'b1, 64'h1C000002, 64'h80FF7F01, 64'hFFFF80FF};
    vecs[3]  = '{1'b0, OP_LH,  1'b1, 64'h1C000001, 64'h80FF7F01, 64'h0};
    vecs[4]  = '{1'b0, OP_LW,  1'b1, 64'h1C000000, 64'h80FF7F01, 64'h80FF7F01};
    vecs[5]  = '{1'b0, OP_LHU, 1'b1, 64'h1C000002, 64'h80FF7F01, 64'h000080FF};
    vecs[6]  = '{1'b0, OP_LB,  1'b1, 64'h1C000001, 64'h80FF7F01, 64'h0000007F};
    vecs[7]  = '{1'b0, OP_LW,  1'b1, 64'h1C000002, 64'h80FF7F01, 64'h0};
    vecs[8]  = '{1'b0, OP_LWU, 1'b1, 64'h1C000000, 64'h80FF7F01, 64'h0};
    vecs[9]  = '{1'b0, OP_LD,  1'b1, 64'h1C000000, 64'h80FF7F01, 64'h0};
    vecs[10] = '{1'b0, 7'h00,  1'b1, 64'h1C000000, 64'h80FF7F01, 64'h0};
    vecs[11] = '{1'b0, OP_LW,  1'b0, 64'hDEADBEEF, 64'h80FF7F01, 64'hDEADBEEF};
    vecs[12] = '{1'b1, OP_LW,  1'b1, 64'h4, 64'h89ABCDEF01234567, 64'hFFFFFFFF89ABCDEF};
    vecs[13] = '{1'b1, OP_LWU, 1'b1, 64'h4, 64'h89ABCDEF01234567, 64'h0000000089ABCDEF};
    vecs[14] = '{1'b1, OP_LD,  1'b1, 64'h0, 64'h89ABCDEF01234567, 64'h89ABCDEF01234567};
    vecs[15] = '{1'b1, OP_LB,  1'b1, 64'h7, 64'h89ABCDEF01234567, 64'hFFFFFFFFFFFFFF89};
    vecs[16] = '{1'b1, OP_LH,  1'b1, 64'h6, 64'h89ABCDEF01234567, 64'hFFFFFFFFFFFF89AB};
    vecs[17] = '{1'b1, OP_LHU, 1'b1, 64'h2, 64'h89ABCDEF01234567, 64'h0000000000000123};
    vecs[18] = '{1'b1, OP_LW,  1'b1, 64'h0, 64'h89ABCDEF01234567, 64'h0000000001234567};
    vecs[19] = '{1'b1, OP_LD,  1'b1, 64'h4, 64'h89ABCDEF01234567, 64'h0};
    vecs[20] = '{1'b1, OP_LBU, 1'b1, 64'h5, 64'h89ABCDEF01234567, 64'h00000000000000CD};
    vecs[21] = '{1'b1, OP_LH,  1'b1, 64'h3, 64'h89ABCDEF01234567, 64'h0};

    // Reset: an offer during reset is ignored and every output stays 0
    clearInputs();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h1C0000F0, 32'h99, 1'b1, 5'd3, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("reset in_ready[%0d]", i), inReady, 0);
      checkOutput($sformatf("reset rf_waddr[%0d]", i), rfWaddr, 0);
      checkOutput($sformatf("reset debug_pc[%0d]", i), dbgPc, 0);
    end
    rst = 1'b1;
    clearInputs();
    #1;
    checkOutput("post-reset in_ready", inReady, 1);
    checkOutput("post-reset rf_we", rfWe, 0);
    applyStimulus(1'b1, 32'h1C000000, 32'h1234, 1'b1, 5'd5, 1'b0, 1'b0, 6'd0);
    tick();
    clearInputs();
    #1;
    checkOutput("basic rf_we", rfWe, 1);
    checkOutput("basic rf_waddr", rfWaddr, 5);
    checkOutput("basic rf_wdata", rfWdata, 64'h1234);
    checkOutput("basic debug_we", dbgWe, 4'hF);
    checkOutput("basic debug_pc", dbgPc, 32'h1C000000);
    checkOutput("basic debug_wnum", dbgWnum, 5);
    checkOutput("basic debug_wdata", dbgWdata, 64'h1234);
    tick();
    checkOutput("basic empty rf_we", rfWe, 0);
    checkOutput("basic empty waddr", rfWaddr, 0);

    // Table-driven load extraction
    for (int i = 0; i < 22; i++) begin
      clearInputs();
      grWe = 1'b1;
      dest = 5'(i + 1);
      if (vecs[i].wide) begin
        inValidW = 1'b1; resultW = vecs[i].result; rdataW = vecs[i].rdata;
        memOpW = vecs[i].memOp; resFromMemW = vecs[i].resFromMem;
      end else begin
        inValid = 1'b1; result = vecs[i].result[31:0]; rdata = vecs[i].rdata[31:0];
        memOp = vecs[i].memOp; resFromMem = vecs[i].resFromMem;
      end
      tick();
      clearInputs();
      #1;
      if (vecs[i].wide) begin
        checkOutput($sformatf("load[%0d] rf_we", i), rfWeW, 1);
        checkOutput($sformatf("load[%0d] rf_wdata", i), rfWdataW, vecs[i].expected);
      end else begin
        checkOutput($sformatf("load[%0d] rf_we", i), rfWe, 1);
        checkOutput($sformatf("load[%0d] rf_wdata", i), rfWdata, vecs[i].expected);
      end
      tick();
    end

    // Full and stall: six offers under stall, exactly four accepted
    clearInputs();
    retireStall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'(32'h1C001000 + i * 4), 32'(32'h1000 + i), 1'b1,
                    5'(i + 1), 1'b0, 1'b0, 6'd0);
      #1;
      checkOutput($sformatf("full in_ready[%0d]", i), inReady, (i < 4));
      if (i > 0) begin
        checkOutput($sformatf("stall rf_we[%0d]", i), rfWe, 0);
        checkOutput($sformatf("stall head waddr[%0d]", i), rfWaddr, 1);
      end
      tick();
    end
    clearInputs();
    for (int j = 0; j < 4; j++) begin
      #1;
      checkOutput($sformatf("drain rf_we[%0d]", j), rfWe, 1);
      checkOutput($sformatf("drain rf_waddr[%0d]", j), rfWaddr, 64'(j + 1));
      checkOutput($sformatf("drain rf_wdata[%0d]", j), rfWdata, 64'(32'h1000 + j));
      checkOutput($sformatf("drain in_ready[%0d]", j), inReady, (j != 0));
      tick();
    end
    checkOutput("drained rf_we", rfWe, 0);
    checkOutput("drained in_ready", inReady, 1);

    // Exception flush: A retires, B flushes, C and D never appear
    retireStall = 1'b1;
    applyStimulus(1'b1, 32'h1C000200, 32'hAAAA, 1'b1, 5'd10, 1'b0, 1'b0, 6'd0);
    tick();
    applyStimulus(1'b1, 32'h1C000100, 32'hBBBB, 1'b1, 5'd11, 1'b1, 1'b0, 6'h0B);
    tick();
    applyStimulus(1'b1, 32'h1C000300, 32'hCCCC, 1'b1, 5'd12, 1'b0, 1'b0, 6'd0);
    tick();
    clearInputs();
    #1;
    checkOutput("exc A rf_we", rfWe, 1);
    checkOutput("exc A rf_waddr", rfWaddr, 10);
    checkOutput("exc A no submit", excSubmit, 0);
    tick();
    applyStimulus(1'b1, 32'h1C000400, 32'hDDDD, 1'b1, 5'd13, 1'b0, 1'b0, 6'd0);
    #1;
    checkOutput("exc B rf_we", rfWe, 0);
    checkOutput("exc B submit", excSubmit, 1);
    checkOutput("exc B flush", thisFlush, 1);
    checkOutput("exc B ertn_submit", ertnSubmit, 0);
    checkOutput("exc B ecode", ecodeSub, 6'h0B);
    checkOutput("exc B pc", excPcSub, 32'h1C000100);
    tick();
    clearInputs();
    #1;
    checkOutput("post-exc submit", excSubmit, 0);
    checkOutput("post-exc flush", thisFlush, 0);
    checkOutput("post-exc rf_we", rfWe, 0);
    checkOutput("post-exc debug_pc", dbgPc, 0);
    checkOutput("post-exc in_ready", inReady, 1);
    tick();
    checkOutput("post-exc D absent", dbgPc, 0);

    // ERTN: held under stall without a pulse, then one flush pulse
    retireStall = 1'b1;
    applyStimulus(1'b1, 32'h1C000500, 32'h5555, 1'b0, 5'd7, 1'b0, 1'b1, 6'd0);
    tick();
    applyStimulus(1'b1, 32'h1C000600, 32'h6666, 1'b1, 5'd8, 1'b0, 1'b0, 6'd0);
    tick();
    inValid = 1'b0;
    #1;
    checkOutput("ertn stalled pulse", ertnSubmit, 0);
    checkOutput("ertn stalled flush", thisFlush, 0);
    checkOutput("ertn stalled pc", dbgPc, 32'h1C000500);
    retireStall = 1'b0;
    #1;
    checkOutput("ertn submit", ertnSubmit, 1);
    checkOutput("ertn flush", thisFlush, 1);
    checkOutput("ertn exc_submit", excSubmit, 0);
    checkOutput("ertn rf_we", rfWe, 0);
    tick();
    clearInputs();
    #1;
    checkOutput("post-ertn submit", ertnSubmit, 0);
    checkOutput("post-ertn flush", thisFlush, 0);
    checkOutput("post-ertn F absent", dbgPc, 0);

    // Occupancy restarts at 0 after a flush: four fit again, fifth refused
    retireStall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'(32'h1C002000 + i * 4), 32'(i), 1'b1,
                    5'(20 + i), 1'b0, 1'b0, 6'd0);
      #1;
      checkOutput($sformatf("refill in_ready[%0d]", i), inReady, (i < 4));
      tick();
    end
    inValid = 1'b0;
    #1;
    checkOutput("refill head pc", dbgPc, 32'h1C002000);

    // Mid-stream reset drops everything and emits no pulse
    rst = 1'b0;
    retireStall = 1'b0;
    #1;
    checkOutput("midreset rf_we", rfWe, 0);
    tick();
    checkOutput("midreset in_ready", inReady, 0);
    checkOutput("midreset debug_pc", dbgPc, 0);
    rst = 1'b1;
    #1;
    checkOutput("after midreset in_ready", inReady, 1);
    checkOutput("after midreset debug_pc", dbgPc, 0);
    checkOutput("after midreset rf_we", rfWe, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
